// File: rtl/gpu_stencil_pkg.sv
// Shared geometry, bank mapping and clear-FSM state type for the stencil cache front end.
package gpu_stencil_pkg;
    localparam int STENCIL_AW    = 15;
    localparam int STENCIL_DW    = 16;
    localparam int STENCIL_BANKS = 8;
    localparam int BANK_W        = $clog2(STENCIL_BANKS);

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_DRAIN,
        CLR_SWEEP,
        CLR_DONE
    } clr_state_t;

    // Word address to cache bank: low two bits of the row plus word parity.
    function automatic logic [BANK_W-1:0] bank_of(input logic [STENCIL_AW-1:0] addr);
        return {addr[7:6], addr[0]};
    endfunction
endpackage

// File: rtl/gpu_stencil_clear_seq.sv
// Bulk-clear sequencer: drains one cycle, then sweeps one straight write per cycle over
// the whole stencil address space and pulses done.
module gpu_stencil_clear_seq
    import gpu_stencil_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_start_i,
    input  logic                  clr_value_i,
    output logic                  clr_busy_o,
    output logic                  clr_done_o,
    output logic                  clr_drain_o,
    output logic                  wr_req_o,
    output logic [STENCIL_AW-1:0] wr_addr_o,
    output logic [STENCIL_DW-1:0] wr_value_o
);
    clr_state_t            r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_drain;
    logic                  r_wr_req;
    logic                  r_value;
    logic [STENCIL_AW-1:0] r_addr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= CLR_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_drain  <= 1'b0;
            r_wr_req <= 1'b0;
            r_value  <= 1'b0;
            r_addr   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CLR_IDLE: begin
                    if (clr_start_i) begin
                        r_state <= CLR_DRAIN;
                        r_addr  <= '0;
                        r_value <= clr_value_i;
                        r_busy  <= 1'b1;
                        r_drain <= 1'b1;
                    end
                end
                CLR_DRAIN: begin
                    r_state  <= CLR_SWEEP;
                    r_drain  <= 1'b0;
                    r_wr_req <= 1'b1;
                end
                CLR_SWEEP: begin
                    r_addr <= r_addr + 1'b1;
                    if (r_addr == '1) begin
                        r_state  <= CLR_DONE;
                        r_wr_req <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                CLR_DONE: r_state <= CLR_IDLE;
                default:  r_state <= CLR_IDLE;
            endcase
        end
    end

    assign clr_busy_o  = r_busy;
    assign clr_done_o  = r_done;
    assign clr_drain_o = r_drain;
    assign wr_req_o    = r_wr_req;
    assign wr_addr_o   = r_addr;
    assign wr_value_o  = {STENCIL_DW{r_value}};
endmodule

// File: rtl/gpu_stencil_arbiter.sv
// Two-requester read/write arbiter for the 8-bank stencil cache with bank-hazard avoidance.
// Optional hazard-error counter enabled by GPU_STENCIL_ARB_ERRCHK_EN.
module gpu_stencil_arbiter
    import gpu_stencil_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_req_i,
    input  logic                  a_we_i,
    input  logic [STENCIL_AW-1:0] a_addr_i,
    input  logic [STENCIL_DW-1:0] a_mask_i,
    input  logic [STENCIL_DW-1:0] a_data_i,
    output logic                  a_ack_o,
    input  logic                  b_req_i,
    input  logic                  b_we_i,
    input  logic [STENCIL_AW-1:0] b_addr_i,
    input  logic [STENCIL_DW-1:0] b_mask_i,
    input  logic [STENCIL_DW-1:0] b_data_i,
    output logic                  b_ack_o,
    input  logic                  clr_start_i,
    input  logic                  clr_value_i,
    output logic                  clr_busy_o,
    output logic                  clr_done_o,
    output logic                  rd_valid_o,
    output logic                  rd_tag_o,
    output logic [STENCIL_DW-1:0] rd_data_o,
    output logic                  stencil_rd_req_o,
    output logic [STENCIL_AW-1:0] stencil_rd_addr_o,
    output logic                  stencil_wr_req_o,
    output logic [STENCIL_AW-1:0] stencil_wr_addr_o,
    output logic [STENCIL_DW-1:0] stencil_wr_mask_o,
    output logic [STENCIL_DW-1:0] stencil_wr_value_o,
    input  logic [STENCIL_DW-1:0] stencil_rd_value_i,
    input  logic                  stencil_error_i,
    output logic                  err_o,
    output logic [7:0]            err_cnt_o
);
    logic                  w_clr_drain;
    logic                  w_clr_wr;
    logic [STENCIL_AW-1:0] w_clr_addr;
    logic [STENCIL_DW-1:0] w_clr_value;

    gpu_stencil_clear_seq u_clear (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_start_i (clr_start_i),
        .clr_value_i (clr_value_i),
        .clr_busy_o  (clr_busy_o),
        .clr_done_o  (clr_done_o),
        .clr_drain_o (w_clr_drain),
        .wr_req_o    (w_clr_wr),
        .wr_addr_o   (w_clr_addr),
        .wr_value_o  (w_clr_value)
    );

    logic                  r_wr_vld;
    logic [BANK_W-1:0]     r_wr_bank;
    logic                  r_rr;
    logic                  r_rd_valid;
    logic                  r_rd_tag;

    logic [1:0]            w_req, w_we, w_prev_hit, w_wr_ok, w_rd_ok, w_wr_gnt, w_rd_gnt;
    logic [STENCIL_AW-1:0] w_addr [2];
    logic [BANK_W-1:0]     w_bank [2];
    logic                  w_wr_fire;
    logic [BANK_W-1:0]     w_wr_bank;
    logic [STENCIL_AW-1:0] w_wr_addr, w_rd_addr;
    logic [STENCIL_DW-1:0] w_wr_mask, w_wr_value;

    assign w_req     = {b_req_i, a_req_i};
    assign w_we      = {b_we_i, a_we_i};
    assign w_addr[0] = a_addr_i;
    assign w_addr[1] = b_addr_i;

    // Index 0 is A, 1 is B; r_rr names the requester preferred on a tie.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign w_bank[gi]     = bank_of(w_addr[gi]);
            assign w_prev_hit[gi] = r_wr_vld && (r_wr_bank == w_bank[gi]);
            assign w_wr_ok[gi]    = w_req[gi] && w_we[gi] && !w_clr_drain && !w_clr_wr
                                    && !w_prev_hit[gi];
            assign w_wr_gnt[gi]   = w_wr_ok[gi] && (!w_wr_ok[1-gi] || (r_rr == 1'(gi)));
            assign w_rd_ok[gi]    = w_req[gi] && !w_we[gi] && !w_clr_drain && !w_prev_hit[gi]
                                    && !(w_wr_fire && (w_wr_bank == w_bank[gi]));
            assign w_rd_gnt[gi]   = w_rd_ok[gi] && (!w_rd_ok[1-gi] || (r_rr == 1'(gi)));
        end
    endgenerate

    always_comb begin
        w_wr_addr  = '0;
        w_wr_mask  = '0;
        w_wr_value = '0;
        if (w_clr_wr) begin
            w_wr_addr  = w_clr_addr;
            w_wr_mask  = '1;
            w_wr_value = w_clr_value;
        end else if (w_wr_gnt[0]) begin
            w_wr_addr  = a_addr_i;
            w_wr_mask  = a_mask_i;
            w_wr_value = a_data_i;
        end else if (w_wr_gnt[1]) begin
            w_wr_addr  = b_addr_i;
            w_wr_mask  = b_mask_i;
            w_wr_value = b_data_i;
        end
    end

    assign w_wr_fire = w_clr_wr || (|w_wr_gnt);
    assign w_wr_bank = bank_of(w_wr_addr);
    assign w_rd_addr = w_rd_gnt[0] ? a_addr_i : (w_rd_gnt[1] ? b_addr_i : '0);

    assign a_ack_o            = w_wr_gnt[0] || w_rd_gnt[0];
    assign b_ack_o            = w_wr_gnt[1] || w_rd_gnt[1];
    assign stencil_rd_req_o   = |w_rd_gnt;
    assign stencil_rd_addr_o  = w_rd_addr;
    assign stencil_wr_req_o   = w_wr_fire;
    assign stencil_wr_addr_o  = w_wr_addr;
    assign stencil_wr_mask_o  = w_wr_mask;
    assign stencil_wr_value_o = w_wr_value;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_vld   <= 1'b0;
            r_wr_bank  <= '0;
            r_rr       <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_tag   <= 1'b0;
        end else begin
            r_wr_vld   <= w_wr_fire;
            r_wr_bank  <= w_wr_bank;
            r_rd_valid <= |w_rd_gnt;
            r_rd_tag   <= w_rd_gnt[1];
            // Only a genuine tie moves the pointer; the preferred side always wins it.
            if ((&w_wr_ok) || (&w_rd_ok))
                r_rr <= ~r_rr;
        end
    end

    assign rd_valid_o = r_rd_valid;
    assign rd_tag_o   = r_rd_tag;
    assign rd_data_o  = r_rd_valid ? stencil_rd_value_i : '0;

`ifdef GPU_STENCIL_ARB_ERRCHK_EN
    logic       r_err;
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (stencil_error_i) begin
            r_err <= 1'b1;
            if (r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;
`else
    logic w_unused_err;
    assign w_unused_err = stencil_error_i;
    assign err_o        = 1'b0;
    assign err_cnt_o    = '0;
`endif
endmodule

// File: tb/tb_gpu_stencil_arbiter.sv
// Self-checking bench for gpu_stencil_arbiter: directed vector table, hand sequences,
// and a randomized run scored against an ideal-memory model and a bank-hazard monitor.
module tb_gpu_stencil_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [14:0] a_addr = '0, b_addr = '0;
    logic [15:0] a_mask = '0, a_data = '0, b_mask = '0, b_data = '0;
    logic        a_ack, b_ack;
    logic        clr_start = 1'b0, clr_value = 1'b0, clr_busy, clr_done;
    logic        rd_valid, rd_tag;
    logic [15:0] rd_data;
    logic        st_rd_req, st_wr_req;
    logic [14:0] st_rd_addr, st_wr_addr;
    logic [15:0] st_wr_mask, st_wr_value;
    logic [15:0] st_rd_value = '0;
    logic        st_err, err;
    logic [7:0]  err_cnt;

    gpu_stencil_arbiter dut (
        .clk_i(clk), .rst_i(rst_n),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_mask_i(a_mask),
        .a_data_i(a_data), .a_ack_o(a_ack),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_mask_i(b_mask),
        .b_data_i(b_data), .b_ack_o(b_ack),
        .clr_start_i(clr_start), .clr_value_i(clr_value), .clr_busy_o(clr_busy),
        .clr_done_o(clr_done), .rd_valid_o(rd_valid), .rd_tag_o(rd_tag), .rd_data_o(rd_data),
        .stencil_rd_req_o(st_rd_req), .stencil_rd_addr_o(st_rd_addr),
        .stencil_wr_req_o(st_wr_req), .stencil_wr_addr_o(st_wr_addr),
        .stencil_wr_mask_o(st_wr_mask), .stencil_wr_value_o(st_wr_value),
        .stencil_rd_value_i(st_rd_value), .stencil_error_i(st_err),
        .err_o(err), .err_cnt_o(err_cnt)
    );

    int n_vec = 0;
    int n_mis = 0;

    function automatic logic [2:0] bk(input logic [14:0] a);
        return {a[7:6], a[0]};
    endfunction

    function automatic logic [15:0] init_val(input logic [14:0] a);
        return {a[7:0], a[14:7]} ^ 16'hA5C3;
    endfunction

    // Cache model: 1-cycle read latency, masked writes, and a monitor of the bank hazard rules.
    bit [15:0] mem [32768];
    bit        seen [32768];
    logic      prev_wv = 1'b0;
    logic [2:0] prev_wb = '0;
    int        hz_cnt = 0;
    logic      err_force = 1'b0;
    logic      hz_now;

    function automatic logic [15:0] mem_rd(input logic [14:0] a);
        return seen[a] ? mem[a] : init_val(a);
    endfunction

    always_comb begin
        hz_now = 1'b0;
        if (st_wr_req && prev_wv && bk(st_wr_addr) == prev_wb) hz_now = 1'b1;
        if (st_rd_req && prev_wv && bk(st_rd_addr) == prev_wb) hz_now = 1'b1;
        if (st_rd_req && st_wr_req && bk(st_rd_addr) == bk(st_wr_addr)) hz_now = 1'b1;
    end
    assign st_err = hz_now | err_force;

    always @(posedge clk) begin
        if (st_wr_req) begin
            mem[st_wr_addr]  <= (mem_rd(st_wr_addr) & ~st_wr_mask) | (st_wr_value & st_wr_mask);
            seen[st_wr_addr] <= 1'b1;
        end
        st_rd_value <= st_rd_req ? mem_rd(st_rd_addr) : 16'h0000;
        prev_wv     <= st_wr_req;
        prev_wb     <= bk(st_wr_addr);
        if (hz_now) hz_cnt <= hz_cnt + 1;
    end

    // Ideal memory: updated in the order requests are acknowledged.
    bit [15:0] shm [32768];
    bit        shs [32768];
    function automatic logic [15:0] sh_rd(input logic [14:0] a);
        return shs[a] ? shm[a] : init_val(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        a_req, a_we;
        logic [14:0] a_addr;
        logic        b_req, b_we;
        logic [14:0] b_addr;
        logic [1:0]  ack;      // {b, a}
        logic        rd_req;
        logic [14:0] rd_addr;
        logic        wr_req;
        logic [14:0] wr_addr;
        logic        rv, rt;
    } vec_t;

    function automatic vec_t mk(input logic ar, input logic aw, input logic [14:0] aa,
                                input logic br, input logic bw, input logic [14:0] ba,
                                input logic [1:0] ack, input logic rq, input logic [14:0] ra,
                                input logic wq, input logic [14:0] wa,
                                input logic rv, input logic rt);
        vec_t v;
        v.a_req = ar; v.a_we = aw; v.a_addr = aa;
        v.b_req = br; v.b_we = bw; v.b_addr = ba;
        v.ack = ack; v.rd_req = rq; v.rd_addr = ra; v.wr_req = wq; v.wr_addr = wa;
        v.rv = rv; v.rt = rt;
        return v;
    endfunction

    localparam int NV = 19;
    localparam logic [14:0] Z = 15'h0000;
    vec_t tbl [NV];

    typedef struct { logic tag; logic [15:0] data; } exp_t;
    exp_t sbq [$];

    logic        pr [2];
    logic        pwe [2];
    logic [14:0] pad [2];
    logic [15:0] pm [2];
    logic [15:0] pd [2];
    int          waitc [2];

    task automatic do_read(input string nm, input logic [14:0] ad, input logic [15:0] exp);
        int w = 0;
        @(negedge clk); a_req = 1'b1; a_we = 1'b0; a_addr = ad; #2;
        while (!a_ack && w < 8) begin @(negedge clk); #2; w++; end
        @(negedge clk); a_req = 1'b0; #2;
        chk(nm, 64'({rd_valid, rd_tag, rd_data}), 64'({1'b1, 1'b0, exp}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed cycle-by-cycle table; starts straight after reset (rr = A, no write in flight).
        tbl[0]  = mk(1'b0,1'b0,Z,       1'b0,1'b0,Z,       2'b00, 1'b0,Z,       1'b0,Z,       1'b0,1'b0);
        tbl[1]  = mk(1'b1,1'b0,15'h0000,1'b1,1'b0,15'h0041,2'b01, 1'b1,15'h0000,1'b0,Z,       1'b0,1'b0);
        tbl[2]  = mk(1'b0,1'b0,Z,       1'b1,1'b0,15'h0041,2'b10, 1'b1,15'h0041,1'b0,Z,       1'b1,1'b0);
        tbl[3]  = mk(1'b0,1'b0,Z,       1'b0,1'b0,Z,       2'b00, 1'b0,Z,       1'b0,Z,       1'b1,1'b1);
        tbl[4]  = mk(1'b1,1'b1,15'h0004,1'b1,1'b1,15'h0102,2'b10, 1'b0,Z,       1'b1,15'h0102,1'b0,1'b0);
        tbl[5]  = mk(1'b1,1'b1,15'h0004,1'b0,1'b0,Z,       2'b00, 1'b0,Z,       1'b0,Z,       1'b0,1'b0);
        tbl[6]  = mk(1'b1,1'b1,15'h0004,1'b0,1'b0,Z,       2'b01, 1'b0,Z,       1'b1,15'h0004,1'b0,1'b0);
        tbl[7]  = mk(1'b0,1'b0,Z,       1'b0,1'b0,Z,       2'b00, 1'b0,Z,       1'b0,Z,       1'b0,1'b0);
        tbl[8]  = mk(1'b1,1'b0,15'h0043,1'b1,1'b1,15'h0041,2'b10, 1'b0,Z,       1'b1,15'h0041,1'b0,1'b0);
        tbl[9]  = mk(1'b1,1'b0,15'h0043,1'b0,1'b0,Z,       2'b00, 1'b0,Z,       1'b0,Z,       1'b0,1'b0);
        tbl[10] = mk(1'b1,1'b0,15'h0043,1'b0,1'b0,Z,       2'b01, 1'b1,15'h0043,1'b0,Z,       1'b0,1'b0);
        tbl[11] = mk(1'b1,1'b0,15'h0081,1'b1,1'b1,15'h0045,2'b11, 1'b1,15'h0081,1'b1,15'h0045,1'b1,1'b0);
        tbl[12] = mk(1'b0,1'b0,Z,       1'b0,1'b0,Z,       2'b00, 1'b0,Z,       1'b0,Z,       1'b1,1'b0);
        tbl[13] = mk(1'b1,1'b1,15'h0006,1'b1,1'b1,15'h0007,2'b01, 1'b0,Z,       1'b1,15'h0006,1'b0,1'b0);
        tbl[14] = mk(1'b0,1'b0,Z,       1'b1,1'b1,15'h0007,2'b10, 1'b0,Z,       1'b1,15'h0007,1'b0,1'b0);
        tbl[15] = mk(1'b0,1'b0,Z,       1'b0,1'b0,Z,       2'b00, 1'b0,Z,       1'b0,Z,       1'b0,1'b0);
        tbl[16] = mk(1'b1,1'b0,15'h0010,1'b1,1'b0,15'h0012,2'b10, 1'b1,15'h0012,1'b0,Z,       1'b0,1'b0);
        tbl[17] = mk(1'b1,1'b0,15'h0010,1'b0,1'b0,Z,       2'b01, 1'b1,15'h0010,1'b0,Z,       1'b1,1'b1);
        tbl[18] = mk(1'b0,1'b0,Z,       1'b0,1'b0,Z,       2'b00, 1'b0,Z,       1'b0,Z,       1'b1,1'b0);

        // Reset state.
        repeat (3) @(negedge clk);
        #2;
        chk("reset_acks", 64'({a_ack, b_ack, rd_valid, rd_tag, rd_data}), 64'd0);
        chk("reset_ports", 64'({st_rd_req, st_rd_addr, st_wr_req, st_wr_addr}), 64'd0);
        chk("reset_clr", 64'({clr_busy, clr_done, err, err_cnt}), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a_req = tbl[i].a_req; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr;
            a_mask = 16'hFFFF; a_data = 16'h1000 + 16'(i);
            b_req = tbl[i].b_req; b_we = tbl[i].b_we; b_addr = tbl[i].b_addr;
            b_mask = 16'hFFFF; b_data = 16'h2000 + 16'(i);
            #2;
            chk($sformatf("vec%0d", i),
                64'({b_ack, a_ack, st_rd_req, st_rd_addr, st_wr_req, st_wr_addr, rd_valid, rd_tag}),
                64'({tbl[i].ack, tbl[i].rd_req, tbl[i].rd_addr, tbl[i].wr_req, tbl[i].wr_addr,
                     tbl[i].rv, tbl[i].rt}));
        end

        // Masked write then read of the same word: read waits two cycles, sees merged data.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0002; a_mask = 16'h00FF; a_data = 16'h1234;
        b_req = 1'b0; #2;
        chk("mw_write_ack", 64'(a_ack), 64'd1);
        @(negedge clk); a_we = 1'b0; #2;
        chk("mr_stall_c1", 64'(a_ack), 64'd0);
        @(negedge clk); #2;
        chk("mr_ack_c2", 64'(a_ack), 64'd1);
        @(negedge clk); a_req = 1'b0; #2;
        chk("mr_data", 64'({rd_valid, rd_tag, rd_data}),
            64'({1'b1, 1'b0, (init_val(15'h0002) & 16'hFF00) | 16'h0034}));

        // Randomized traffic on 0x200..0x2FF (all 8 banks), scored against the ideal memory.
        pr[0] = 1'b0; pr[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!pr[r] && c < 2990 && $urandom_range(0, 99) < 60) begin
                    pr[r]    = 1'b1;
                    pwe[r]   = 1'($urandom_range(0, 1));
                    pad[r]   = 15'h0200 | 15'($urandom_range(0, 255));
                    pm[r]    = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
                    pd[r]    = 16'($urandom);
                    waitc[r] = 0;
                end
            end
            a_req = pr[0]; a_we = pwe[0]; a_addr = pad[0]; a_mask = pm[0]; a_data = pd[0];
            b_req = pr[1]; b_we = pwe[1]; b_addr = pad[1]; b_mask = pm[1]; b_data = pd[1];
            #2;
            if (rd_valid) begin
                if (sbq.size() == 0) begin
                    chk("rnd_unexpected_rd", 64'(rd_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rnd_rd_tag", 64'(rd_tag), 64'(e.tag));
                    chk("rnd_rd_data", 64'(rd_data), 64'(e.data));
                end
            end
            for (int r = 0; r < 2; r++) begin
                logic ack;
                ack = (r == 0) ? a_ack : b_ack;
                if (pr[r]) begin
                    if (ack) begin
                        if (pwe[r]) begin
                            shm[pad[r]] = (sh_rd(pad[r]) & ~pm[r]) | (pd[r] & pm[r]);
                            shs[pad[r]] = 1'b1;
                        end else begin
                            exp_t e;
                            e.tag = 1'(r);
                            e.data = sh_rd(pad[r]);
                            sbq.push_back(e);
                        end
                        pr[r] = 1'b0;
                    end else begin
                        waitc[r]++;
                        if (waitc[r] > 16) begin
                            chk($sformatf("rnd_starve_%0d", r), 64'(waitc[r]), 64'd16);
                            pr[r] = 1'b0;
                        end
                    end
                end else if (ack) begin
                    chk($sformatf("rnd_spurious_ack_%0d", r), 64'(ack), 64'd0);
                end
            end
        end
        chk("rnd_sb_empty", 64'(sbq.size()), 64'd0);
        chk("no_hazards", 64'(hz_cnt), 64'd0);

        // Error flag: three cycles of stencil_error_i, then reset clears it.
        @(negedge clk); a_req = 1'b0; b_req = 1'b0; err_force = 1'b1;
        repeat (3) @(negedge clk);
        err_force = 1'b0; #2;
`ifdef GPU_STENCIL_ARB_ERRCHK_EN
        chk("err_after_3", 64'({err, err_cnt}), 64'({1'b1, 8'd3}));
`else
        chk("err_disabled", 64'({err, err_cnt}), 64'd0);
`endif
        @(negedge clk); rst_n = 1'b0; #2;
        chk("err_reset", 64'({err, err_cnt}), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Bulk clear to ones while A streams writes to 0x0010.
        begin
            int ncyc = 1;
            int leak = 0;
            @(negedge clk);
            a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0010; a_mask = 16'hFFFF; a_data = 16'h0000;
            clr_start = 1'b1; clr_value = 1'b1; #2;
            for (int k = 0; k < 40000; k++) begin
                @(negedge clk); clr_start = 1'b0; #2;
                ncyc++;
                if (k == 1000) chk("clr_busy_mid", 64'(clr_busy), 64'd1);
                if (clr_done) break;
                if (a_ack) leak++;
            end
            chk("clr_done_cycles", 64'(ncyc), 64'd32771);
            chk("clr_a_ack_leak", 64'(leak), 64'd0);
        end
        @(negedge clk); a_req = 1'b0; #2;
        chk("clr_done_pulse", 64'({clr_done, clr_busy}), 64'd0);
        do_read("clr_readback_last", 15'h7FFF, 16'hFFFF);
        do_read("clr_readback_rand", 15'($urandom_range(32, 32767)), 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/gpu_stencil_arbiter.md
# gpu_stencil_arbiter

Sequencer and arbiter in front of the 8-bank stencil cache. It shares the cache's single read port and single write port between two pixel-side requesters (A: rasterizer, B: copy/fill unit) and an internal bulk-clear sequencer. Issue is scheduled so the cache's per-bank hazards never occur: no back-to-back writes to one bank, and no read while a write is in flight on that bank. Read data is returned tagged with the owning requester.

## Interface
Parameters: none. Cache geometry is fixed by the package constants.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, asynchronous, active-low.
- a_req_i  in  1  requester A has a request; held stable until acked.
- a_we_i  in  1  1 = write, 0 = read.
- a_addr_i  in  15  stencil word address.
- a_mask_i  in  16  write bit mask (16'hFFFF = straight write).
- a_data_i  in  16  write data.
- a_ack_o  out  1  request issued this cycle.
- b_req_i, b_we_i, b_addr_i, b_mask_i, b_data_i, b_ack_o  same as A, for requester B.
- clr_start_i  in  1  pulse; start a bulk clear.
- clr_value_i  in  1  clear bit, replicated to 16 bits.
- clr_busy_o  out  1  clear in progress.
- clr_done_o  out  1  one-cycle pulse on clear completion.
- rd_valid_o  out  1  read data valid.
- rd_tag_o  out  1  0 = A, 1 = B.
- rd_data_o  out  16  read data.
- stencil_rd_req_o, stencil_rd_addr_o[14:0]  out  cache read port.
- stencil_wr_req_o, stencil_wr_addr_o[14:0], stencil_wr_mask_o[15:0], stencil_wr_value_o[15:0]  out  cache write port.
- stencil_rd_value_i  in  16  cache read data, valid 1 cycle after read request.
- stencil_error_i  in  1  cache hazard flag; used only with the macro.
- err_o  out  1; err_cnt_o  out  8  only with the macro.

## Operation
- Bank of an address: {addr[7:6], addr[0]}.
- Hazard state: wr_vld_q and wr_bank_q hold the write issued in the previous cycle.
  - A write to bank w is blocked if wr_vld_q and wr_bank_q == w.
  - A read to bank r is blocked if (wr_vld_q and wr_bank_q == r), or if a write to r issues this cycle.
- Per cycle, at most one read and one write are issued. Write selection is resolved first; read eligibility is then checked against it.
- A vs B contention for the same port is resolved round-robin. rr_q points to the preferred requester and flips to the other requester whenever the preferred one wins a contested grant.
  - Uncontested eligible requests always issue.
  - A blocked winner does not block the other requester.
- The cache port outputs and ack are combinational from the grant. Outputs are zero when idle.
- Read return: rd_valid_o is asserted 1 cycle after read issue. rd_tag_o comes from a registered tag, and rd_data_o = stencil_rd_value_i.
- Ordering: per-requester order is preserved, because each requester has one outstanding request. A read after a write to the same address returns the new data: the earliest same-bank read is 2 cycles after the write, by the hazard rule.
- Clear FSM states and transitions:
  - IDLE: on clr_start_i, load addr = 0 and go to DRAIN.
  - DRAIN: A and B acks are held low. Wait 1 cycle so in-flight writes retire, then go to SWEEP.
  - SWEEP: issue one straight write per cycle, addr +1. Consecutive addresses differ in bit 0, so the hazard rule never stalls the sweep. At addr 32767, go to DONE.
  - DONE: clr_done_o = 1 for 1 cycle, then IDLE.
- clr_start_i while busy is ignored.

## Timing
- Reset: every output is 0, FSM is IDLE, rr_q = A, and wr_vld_q = 0. Async assert; deassert is synchronous to clk_i via an external synchronizer.
- Reset mid-clear abandons the sweep; cache contents are undefined.
- Issue latency is 0 cycles (ack in the request cycle). Read data latency is 1 cycle.
- A full clear takes 32768 + 3 cycles, start pulse to done pulse.

## Configuration
- GPU_STENCIL_ARB_ERRCHK_EN defined:
  - Each stencil_error_i assertion sets sticky err_o and increments err_cnt_o, saturating at 255.
  - Both are cleared only by reset.
- Undefined: err_o = 0, err_cnt_o = 0, and stencil_error_i is ignored.

## Structure
- Package gpu_stencil_pkg holds:
  - STENCIL_AW = 15, STENCIL_DW = 16, STENCIL_BANKS = 8;
  - the bank-ID extraction function;
  - the clear FSM state enum.
- Sub-module gpu_stencil_clear_seq contains the clear FSM and address counter. It presents one write request to the arbiter, which gives it absolute priority.

## Test plan
- A read 0x0000 and B read 0x0041 in the same cycle: one granted (rr = A, so A), B granted next cycle; tags 0 then 1 at +1 cycle.
- A write 0x0002, mask 0x00FF, data 0x1234, then A read 0x0002: read acked 2 cycles later, returns (old & 0xFF00) | 0x0034.
- A and B both write to bank 0 on consecutive requests: second write delayed 1 cycle; stencil_error_i never asserted.
- B write bank 3 and A read bank 3 in the same cycle: write issues, read stalls 2 cycles; A read bank 5 in the same cycle issues immediately.
- clr_start_i with clr_value_i = 1 while A streams writes: A acks stop, 32771 cycles to clr_done_o; a random readback returns 0xFFFF.
- With GPU_STENCIL_ARB_ERRCHK_EN: force stencil_error_i high 3 cycles → err_o = 1, err_cnt_o = 3; reset → both 0.
